// File: rtl/awg_pkg.sv
// Shared constants for the AWG command path: sync byte, field codes,
// decoder state encoding and waveform type codes.
package awg_pkg;

    localparam logic [7:0] AWG_SYNC = 8'hA5;

    localparam logic [1:0] FLD_WAVE = 2'd0;
    localparam logic [1:0] FLD_FREQ = 2'd1;
    localparam logic [1:0] FLD_AMP  = 2'd2;
    localparam logic [1:0] FLD_OFS  = 2'd3;

    localparam logic [1:0] WAVE_SINE     = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_SAW      = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DHI,
        ST_DLO,
        ST_CKS
    } dec_state_e;

    function automatic logic [7:0] pkt_cksum(input logic [7:0] hdr,
                                             input logic [7:0] dhi,
                                             input logic [7:0] dlo);
        return hdr ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/awg_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while running and emits a
// one-cycle expire pulse after TIMEOUT_CYC cycles without a clear.
module awg_byte_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A byte arriving in the expiry cycle suppresses the pulse.
    assign expire_o = run_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        if (clear_i || !run_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/awg_cmd_decoder.sv
// Framed multi-channel UART command decoder for the AWG.
// Define AWG_CMD_CKSUM_EN for 5-byte packets with an XOR checksum byte.
module awg_cmd_decoder
    import awg_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FREQ_W      = 16,
    parameter int AMP_W       = 10,
    parameter int OFS_W       = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 uart_data,
    input  logic                       data_valid,
    output logic [2*NUM_CH-1:0]        waveform_type,
    output logic [FREQ_W*NUM_CH-1:0]   frequency,
    output logic [AMP_W*NUM_CH-1:0]    amplitude,
    output logic [OFS_W*NUM_CH-1:0]    dc_offset,
    output logic [NUM_CH-1:0]          cfg_update,
    output logic                       cmd_ok,
    output logic                       cmd_err,
    output logic                       busy
);

    dec_state_e state_q;
    logic [3:0] chan_q;
    logic [1:0] fld_q;
    logic [7:0] dhi_q;
`ifdef AWG_CMD_CKSUM_EN
    logic [7:0] hdr_q;
    logic [7:0] dlo_q;
`endif

    logic [NUM_CH-1:0][1:0]       wave_q;
    logic [NUM_CH-1:0][FREQ_W-1:0] freq_q;
    logic [NUM_CH-1:0][AMP_W-1:0]  amp_q;
    logic [NUM_CH-1:0][OFS_W-1:0]  ofs_q;
    logic [NUM_CH-1:0]             upd_q;
    logic                          ok_q;
    logic                          err_q;

    logic        expire;
    logic        fin_byte;
    logic        fin_ok;
    logic [15:0] fin_data;

    assign busy = (state_q != ST_IDLE);

    awg_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (data_valid),
        .run_i    (busy),
        .expire_o (expire)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fin_byte = 1'b0;
        fin_data = '0;
        fin_ok   = 1'b0;
`ifdef AWG_CMD_CKSUM_EN
        fin_byte = data_valid && (state_q == ST_CKS);
        fin_data = {dhi_q, dlo_q};
        fin_ok   = ({1'b0, chan_q} < 5'(NUM_CH))
                && (uart_data == pkt_cksum(hdr_q, dhi_q, dlo_q));
`else
        fin_byte = data_valid && (state_q == ST_DLO);
        fin_data = {dhi_q, uart_data};
        fin_ok   = ({1'b0, chan_q} < 5'(NUM_CH));
`endif
    end

    // NOTE: the configuration arrays are reset explicitly because the
    // waveform engines must start from defined, non-zero settings.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            fld_q   <= '0;
            dhi_q   <= '0;
`ifdef AWG_CMD_CKSUM_EN
            hdr_q   <= '0;
            dlo_q   <= '0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                wave_q[c] <= WAVE_SINE;
                freq_q[c] <= FREQ_W'(1);
                amp_q[c]  <= '1;
                ofs_q[c]  <= OFS_W'(1) << (OFS_W - 1);
            end
            upd_q <= '0;
            ok_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            upd_q <= '0;
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (data_valid) begin
                case (state_q)
                    ST_IDLE: if (uart_data == AWG_SYNC) state_q <= ST_HDR;
                    ST_HDR: begin
                        chan_q  <= uart_data[7:4];
                        fld_q   <= uart_data[1:0];
`ifdef AWG_CMD_CKSUM_EN
                        hdr_q   <= uart_data;
`endif
                        state_q <= ST_DHI;
                    end
                    ST_DHI: begin
                        dhi_q   <= uart_data;
                        state_q <= ST_DLO;
                    end
`ifdef AWG_CMD_CKSUM_EN
                    ST_DLO: begin
                        dlo_q   <= uart_data;
                        state_q <= ST_CKS;
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end else if (expire) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
            end

            // Final byte: commit the field or reject the whole packet.
            if (fin_byte) begin
                if (fin_ok) begin
                    ok_q <= 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (chan_q == 4'(c)) begin
                            upd_q[c] <= 1'b1;
                            case (fld_q)
                                FLD_WAVE: wave_q[c] <= fin_data[1:0];
                                FLD_FREQ: freq_q[c] <= fin_data[FREQ_W-1:0];
                                FLD_AMP:  amp_q[c]  <= fin_data[AMP_W-1:0];
                                default:  ofs_q[c]  <= fin_data[OFS_W-1:0];
                            endcase
                        end
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign waveform_type = wave_q;
    assign frequency     = freq_q;
    assign amplitude     = amp_q;
    assign dc_offset     = ofs_q;
    assign cfg_update    = upd_q;
    assign cmd_ok        = ok_q;
    assign cmd_err       = err_q;

endmodule
